uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel receive end of the 12-bit UART frame produced by the board transmitter.
//  Frame on the wire, in time order:
//   - start bit (0)
//   - 8 data bits, LSB first
//   - even-parity bit (XOR of the data bits)
//   - 2 stop bits (1)
//  The block recovers the byte, checks parity and framing, and presents the result with a
//  one-cycle valid strobe to downstream logic (LEDs / seven-segment display).
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per bit period (50 MHz / 9600 baud); must be >= 4
//  SYNC_STAGES   2     flops in the rx_in metastability synchronizer; must be >= 2
// PORTS
//  clk         in   1  system clock; every flop is clocked on the rising edge
//  rst_n       in   1  asynchronous active-low reset
//  rx_in       in   1  serial line, idle high, asynchronous to clk
//  data_out    out  8  last received byte; held until the next frame completes
//  data_valid  out  1  one-cycle pulse when a frame completes (also asserted on error)
//  parity_err  out  1  received parity bit != ^data; updated with data_valid, held until then
//  frame_err   out  1  a stop bit sampled 0; updated with data_valid, held until then
//  busy        out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: every output is 0, FSM in IDLE, counters 0. Reset mid-frame aborts the frame; no strobe.
//  Input path: rx_in passes through SYNC_STAGES flops; rx_s is the synchronized line.
//  Counters:
//   - bit_cnt counts 0..CLKS_PER_BIT-1, then wraps to 0.
//   - idx counts data bits 0..7.
//  Sampling: one sample per bit, taken at bit_cnt == CLKS_PER_BIT/2 - 1 (mid-bit).
//   - START is the only state that samples at that point; it re-aligns bit_cnt to 0 there.
//   - Every later bit is sampled at bit_cnt == CLKS_PER_BIT-1, i.e. one full period later.
//  FSM states and transitions:
//   - IDLE:   rx_s == 0 -> START, bit_cnt cleared.
//   - START:  mid-bit sample. If rx_s == 1 it is a glitch or false start: back to IDLE,
//             no strobe, outputs unchanged. Else -> DATA.
//   - DATA:   shift rx_s into shreg[idx] on each sample. After idx == 7 -> PARITY.
//   - PARITY: store the sampled bit as par_rx -> STOP1.
//   - STOP1:  sample; a 0 sets the internal ferr flag -> STOP2.
//   - STOP2:  sample; a 0 sets ferr -> DONE.
//   - DONE:   single cycle. data_out <= shreg; parity_err <= par_rx ^ (^shreg);
//             frame_err <= ferr; data_valid = 1 this cycle only -> IDLE.
//  After DONE the FSM returns to IDLE. If the line is already low there, START is entered on
//  the next clk. Back-to-back frames with zero idle time are received without loss.
//  A line held low for the whole frame (break condition) gives data_out = 8'h00,
//  parity_err = 0, frame_err = 1.
//  Errors do not suppress data_valid; downstream qualifies data_out with the error flags.
//  Latency: data_valid rises SYNC_STAGES + 1 clk after the second stop-bit sample point.
// STRUCTURE
//  Package uart_pkg:
//   - rx_state_t enum: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE
//   - localparams DATA_BITS = 8, STOP_BITS = 2, FRAME_BITS = 12
//   - function even_parity(byte)
//   The transmitter shares this package.
//  Sub-module uart_rx_sync: parameterised SYNC_STAGES flop chain, reset value 1 (idle high).
//  The FSM, both counters and the output registers stay in uart_receiver.
// TESTING (bench CLKS_PER_BIT = 16; the bench drives rx_in with a transmitter model)
//  1. Byte 8'hA5, parity 0, stops 11 -> one data_valid; data_out = A5; both errors 0.
//  2. Byte 8'h01, parity forced 0 -> data_out = 01, parity_err = 1, frame_err = 0.
//  3. Byte 8'h3C, second stop bit driven 0 -> data_out = 3C, frame_err = 1, parity_err = 0.
//  4. 4-clk low pulse on idle line -> busy rises then falls; no data_valid; outputs unchanged.
//  5. Frames 8'h55 then 8'hFF with no idle gap -> two strobes, values 55 then FF.
//  6. rst_n low during DATA of 8'h7E, released mid-frame -> all outputs 0; no strobe until the
//     next clean start bit; the following frame 8'h12 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame definitions for the receiver and transmitter
// Purpose: receiver state encoding, frame geometry constants and the parity helper.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 2;
  localparam int FRAME_BITS = 12;

  // Even parity: XOR of all data bits, so data plus parity has an even count of ones.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - metastability synchronizer for the asynchronous serial line
// Purpose: passes rx_in through SYNC_STAGES flops; flops reset to 1 so the line looks idle.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   rx_in  in  1  raw serial line, asynchronous to clk
//   rx_s   out 1  synchronized serial line
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 12-bit UART frame receiver (start, 8 data LSB first, even parity, 2 stop)
// Purpose: recovers the byte, checks parity and framing, strobes data_valid for one cycle.
// Ports:
//   clk         in  1  system clock, rising edge
//   rst_n       in  1  asynchronous active-low reset
//   rx_in       in  1  serial line, idle high, asynchronous to clk
//   data_out    out 8  last received byte, held until the next frame completes
//   data_valid  out 1  one-cycle pulse per completed frame (errors included)
//   parity_err  out 1  received parity bit disagrees with the data, updated with data_valid
//   frame_err   out 1  a stop bit was sampled low, updated with data_valid
//   busy        out 1  receiver is not idle
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t             state;
  logic                  rx_s;
  logic [CNT_W-1:0]      bit_cnt;
  logic [2:0]            idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_rx;
  logic                  ferr;
  logic                  bit_end;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_in (rx_in),
    .rx_s  (rx_s)
  );

  // After START re-aligns bit_cnt at mid-bit, the wrap point lands mid-bit of every later bit.
  assign bit_end = (bit_cnt == LAST_CNT);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_rx     <= 1'b0;
      ferr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (bit_cnt == MID_CNT) begin
            bit_cnt <= '0;
            idx     <= '0;
            ferr    <= 1'b0;
            // A line already back high at mid-bit was a glitch, not a start bit.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CNT_W'(1);
          if (bit_end) begin
            shreg[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= PARITY;
            end
          end
        end

        PARITY: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CNT_W'(1);
          if (bit_end) begin
            par_rx <= rx_s;
            state  <= STOP1;
          end
        end

        STOP1: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CNT_W'(1);
          if (bit_end) begin
            if (!rx_s) begin
              ferr <= 1'b1;
            end
            state <= STOP2;
          end
        end

        STOP2: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CNT_W'(1);
          if (bit_end) begin
            if (!rx_s) begin
              ferr <= 1'b1;
            end
            state <= DONE;
          end
        end

        DONE: begin
          data_out   <= shreg;
          parity_err <= par_rx ^ even_parity(shreg);
          frame_err  <= ferr;
          data_valid <= 1'b1;
          bit_cnt    <= '0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver with a serial transmitter model
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Entries are {data, parity_err, frame_err}.
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) obs_q.push_back({data_out, parity_err, frame_err});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the receiver must report for a frame as it was put on the wire.
  function automatic logic [9:0] model(input logic [7:0] d, input logic par_bit,
                                       input logic s1, input logic s2);
    int  ones;
    logic perr;
    ones = $countones(d);
    perr = (par_bit != logic'(ones % 2));
    return {d, perr, ~(s1 & s2)};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic s1,
                            input logic s2, input int gap_bits);
    logic [11:0] bits;
    logic        par_bit;
    par_bit = logic'($countones(d) % 2) ^ flip_par;
    bits    = {s2, s1, par_bit, d, 1'b0};
    exp_q.push_back(model(d, par_bit, s1, s2));
    for (int i = 0; i < 12; i++) begin
      rx_in = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (gap_bits * CPB) @(negedge clk);
  endtask

  task automatic compare_queues(input string tag);
    int n;
    repeat (8) @(negedge clk);
    check({tag, " strobes"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s frame%0d", tag, i), obs_q[i], exp_q[i]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic seen_busy;
    repeat (4) @(negedge clk);
    check("reset data_out", data_out, 8'h00);
    check("reset data_valid", data_valid, 1'b0);
    check("reset parity_err", parity_err, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 2);
    compare_queues("clean A5");

    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 2);
    compare_queues("parity 01");

    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 2);
    compare_queues("stop2 3C");

    // Short low pulse: busy must rise, then fall, with no strobe and outputs held.
    seen_busy = 1'b0;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    check("glitch busy seen", seen_busy, 1'b1);
    check("glitch busy idle", busy, 1'b0);
    check("glitch data_out held", data_out, 8'h3C);
    check("glitch frame_err held", frame_err, 1'b1);
    compare_queues("glitch");

    // Break: line low for the whole frame.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 2);
    compare_queues("break");

    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 2);
    compare_queues("back2back");

    // Reset during DATA of 8'h7E, released while the line sits in STOP1.
    fork
      send_frame(8'h7E, 1'b0, 1'b1, 1'b1, 2);
      begin
        repeat (CPB * 4 + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset data_out", data_out, 8'h00);
        check("midreset busy", busy, 1'b0);
        check("midreset data_valid", data_valid, 1'b0);
        repeat (CPB * 6) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    check("after reset strobes", obs_q.size(), 0);
    check("after reset data_out", data_out, 8'h00);
    check("after reset busy", busy, 1'b0);
    obs_q.delete();
    exp_q.delete();
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 2);
    compare_queues("post reset 12");

    // Random frames with random error injection and idle gaps (including none).
    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      logic       flip, s1, s2;
      int         gap;
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      s1   = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 2);
      s2   = (gap == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      send_frame(d, flip, s1, s2, gap);
    end
    compare_queues("random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
